// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: two requester FIFOs share the register file write port.
// Round-robin pop feeds a registered write stage (rf_reg_write/rf_rd/rf_write_data).
// Optional feature macro: WB_HAZARD_CHECK_EN adds read-after-write hazard query ports.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              hold,
`ifdef WB_HAZARD_CHECK_EN
  input  logic [ADDR_W-1:0] query_rs1,
  input  logic [ADDR_W-1:0] query_rs2,
  output logic              hazard_rs1,
  output logic              hazard_rs2,
`endif
  output logic              rf_reg_write,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              last_grant,
  output logic              idle
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [1:0]        in_valid, ready, push, pop, nonempty;
  logic [ADDR_W-1:0] in_rd   [2];
  logic [DATA_W-1:0] in_data [2];

  logic [PW-1:0]     wptr_q  [2];
  logic [PW-1:0]     rptr_q  [2];
  logic [CW-1:0]     count_q [2];
  logic [ADDR_W-1:0] rd_mem_q   [2][DEPTH];
  logic [DATA_W-1:0] data_mem_q [2][DEPTH];

  logic              pop_idx;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;

  logic              rf_reg_write_q, last_grant_q;
  logic [ADDR_W-1:0] rf_rd_q;
  logic [DATA_W-1:0] rf_write_data_q;

  assign in_valid   = {req1_valid, req0_valid};
  assign in_rd[0]   = req0_rd;
  assign in_rd[1]   = req1_rd;
  assign in_data[0] = req0_data;
  assign in_data[1] = req1_data;

  // Ready looks only at the registered count, never at a same-cycle pop.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ready[i]    = (count_q[i] != CW'(DEPTH));
      nonempty[i] = (count_q[i] != '0);
      push[i]     = in_valid[i] & ready[i];
    end
  end

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];

  // FIFO pointers and occupancy; queued entries are dropped on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        wptr_q[i]  <= '0;
        rptr_q[i]  <= '0;
        count_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wptr_q[i] <= wptr_q[i] + PW'(1);
        if (pop[i])  rptr_q[i] <= rptr_q[i] + PW'(1);
        if (push[i] && !pop[i]) count_q[i] <= count_q[i] + CW'(1);
        else if (pop[i] && !push[i]) count_q[i] <= count_q[i] - CW'(1);
      end
    end
  end

  // FIFO storage; contents are qualified by count so they need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        rd_mem_q[i][wptr_q[i]]   <= in_rd[i];
        data_mem_q[i][wptr_q[i]] <= in_data[i];
      end
    end
  end

  // Round-robin pick: with both non-empty, serve the one not granted last.
  always_comb begin
    pop = '0;
    if (!hold) begin
      if (nonempty[0] && (!nonempty[1] || last_grant_q)) pop[0] = 1'b1;
      else if (nonempty[1])                             pop[1] = 1'b1;
    end
  end

  assign pop_idx   = pop[1];
  assign head_rd   = rd_mem_q[pop_idx][rptr_q[pop_idx]];
  assign head_data = data_mem_q[pop_idx][rptr_q[pop_idx]];

  // Write stage: one-cycle strobe per popped entry, rd==0 consumed silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_reg_write_q  <= 1'b0;
      rf_rd_q         <= '0;
      rf_write_data_q <= '0;
      last_grant_q    <= 1'b1;
    end else begin
      rf_reg_write_q <= 1'b0;
      if (|pop) begin
        rf_rd_q         <= head_rd;
        rf_write_data_q <= head_data;
        rf_reg_write_q  <= (head_rd != '0);
        last_grant_q    <= pop_idx;
      end
    end
  end

  assign rf_reg_write  = rf_reg_write_q;
  assign rf_rd         = rf_rd_q;
  assign rf_write_data = rf_write_data_q;
  assign last_grant    = last_grant_q;
  assign idle          = !nonempty[0] && !nonempty[1] && !rf_reg_write_q;

`ifdef WB_HAZARD_CHECK_EN
  // Pending-write match against every occupied FIFO slot and the live write stage.
  always_comb begin
    hazard_rs1 = 1'b0;
    hazard_rs2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (CW'(k) < count_q[i]) begin
          if (rd_mem_q[i][rptr_q[i] + PW'(k)] == query_rs1) hazard_rs1 = 1'b1;
          if (rd_mem_q[i][rptr_q[i] + PW'(k)] == query_rs2) hazard_rs2 = 1'b1;
        end
      end
    end
    if (rf_reg_write_q && (rf_rd_q == query_rs1)) hazard_rs1 = 1'b1;
    if (rf_reg_write_q && (rf_rd_q == query_rs2)) hazard_rs2 = 1'b1;
    if (query_rs1 == '0) hazard_rs1 = 1'b0;
    if (query_rs2 == '0) hazard_rs2 = 1'b0;
  end
`endif

endmodule
